// File: rtl/lsu_if.sv
// ============================================================================
// Module : lsu_if
// Brief  : Core-side request and memory-bus signal bundle for the LSU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lsu_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, req_we, funct3, addr, wdata, bus_ready, bus_rdata,
    output stall, done, err, rdata, bus_valid, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, req_we, funct3, addr, wdata, bus_ready, bus_rdata,
    input  stall, done, err, rdata, bus_valid, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module : lsu
// Brief  : Single-outstanding load/store unit bridging the core to a 32-bit bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave io
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_accept;
  logic         w_reject;
  logic         w_ok;
  logic         w_abort;
  logic         w_tmo;
  logic         w_misal;
  logic         w_illegal;
  logic         w_legal;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata;
  logic [31:0]  w_shift;
  logic [31:0]  w_ld;

  logic         r_bus_we;
  logic [31:0]  r_bus_addr;
  logic [3:0]   r_bus_be;
  logic [31:0]  r_bus_wdata;
  logic [2:0]   r_f3;
  logic [1:0]   r_lane;
  logic [CW-1:0] r_cnt;
  logic         r_err;
  logic [31:0]  r_rdata;

  // Request decode: lane enables, replicated store data, alignment check
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    w_misal = 1'b0;
    case (io.funct3[1:0])
      2'b00: begin
        if (io.req_we) begin
          w_be    = 4'b0001 << io.addr[1:0];
          w_wdata = {4{io.wdata[7:0]}};
        end
      end
      2'b01: begin
        w_misal = io.addr[0];
        if (io.req_we) begin
          w_be    = 4'b0011 << io.addr[1:0];
          w_wdata = {2{io.wdata[15:0]}};
        end
      end
      2'b10: begin
        w_misal = |io.addr[1:0];
        if (io.req_we) begin
          w_wdata = io.wdata;
        end
      end
      default: begin
        w_misal = 1'b0;
      end
    endcase
  end

  assign w_illegal = (io.funct3[1:0] == 2'b11)
                   | (io.funct3[2] & io.funct3[1])
                   | (io.req_we & io.funct3[2]);
  assign w_legal   = ~w_illegal & ~w_misal;
  assign w_tmo     = (TIMEOUT != 0) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // bus_ready is checked before the timeout so a same-cycle accept wins
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_ok     = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io.req_valid) begin
          if (w_legal) begin
            w_next   = S_REQ;
            w_accept = 1'b1;
          end else begin
            w_next   = S_DONE;
            w_reject = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (io.bus_ready) begin
          w_next = S_DONE;
          w_ok   = 1'b1;
        end else if (w_tmo) begin
          w_next  = S_DONE;
          w_abort = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_shift = io.bus_rdata >> {r_lane, 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_ld = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ld = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ld = {24'h0, w_shift[7:0]};
      3'b101:  w_ld = {16'h0, w_shift[15:0]};
      default: w_ld = io.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_f3        <= 3'b0;
      r_lane      <= 2'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      if (w_accept) begin
        r_bus_we    <= io.req_we;
        r_bus_addr  <= {io.addr[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_f3        <= io.funct3;
        r_lane      <= io.addr[1:0];
      end
      if (w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == S_REQ) && !io.bus_ready && !w_tmo && (TIMEOUT != 0)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_reject || w_abort) begin
        r_err <= 1'b1;
      end else if (w_ok) begin
        r_err <= 1'b0;
      end
      if (w_ok && !r_bus_we) begin
        r_rdata <= w_ld;
      end
    end
  end

  assign io.stall     = io.req_valid & (r_state != S_DONE);
  assign io.done      = (r_state == S_DONE);
  assign io.err       = (r_state == S_DONE) & r_err;
  assign io.rdata     = r_rdata;
  assign io.bus_valid = (r_state == S_REQ);
  assign io.bus_we    = r_bus_we;
  assign io.bus_addr  = r_bus_addr;
  assign io.bus_be    = r_bus_be;
  assign io.bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum cycles in REQ without bus_ready before abort; 0 disables the timeout.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  input  1  load/store instruction present; held stable by the core while stall=1.
REQ-005 Port: req_we  input  1  1=store, 0=load.
REQ-006 Port: funct3  input  3  size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-007 Port: addr  input  32  effective address (ALU result).
REQ-008 Port: wdata  input  32  store data (rs2 value), low bits significant.
REQ-009 Port: stall  output  1  freezes PC and register-file write.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: err  output  1  valid with done: misaligned address, illegal funct3, or bus timeout.
REQ-012 Port: rdata  output  32  aligned, extended load result.
REQ-013 Port: bus_valid  output  1  bus request.
REQ-014 Port: bus_ready  input  1  bus accept; for loads, bus_rdata is valid in the same cycle.
REQ-015 Port: bus_we, bus_addr[31:0], bus_be[3:0], bus_wdata[31:0]  output  request fields; bus_addr = {addr[31:2],2'b00}.
REQ-016 Port: bus_rdata  input  32  read word.

Function
REQ-017 FSM states SHALL be IDLE, REQ and DONE.
- IDLE with req_valid=1 and a legal, aligned request: latch the bus fields, then go to REQ.
- IDLE with req_valid=1 and an illegal or misaligned request: go to DONE with err=1; no bus transaction.
REQ-018 stall SHALL equal req_valid AND (state != DONE), computed combinationally.
REQ-019 In REQ, bus_valid=1 with all bus fields held stable; on bus_ready=1, capture bus_rdata (loads only), then go to DONE.
REQ-020 In DONE, done=1 and stall=0 for exactly one cycle, then return to IDLE; req_valid is not sampled in DONE.
REQ-021 Latency with a zero-wait bus: request accepted in cycle 0, bus_valid in cycle 1, done in cycle 2; each wait cycle adds one cycle.
REQ-022 Misalignment: half with addr[0]=1; word with addr[1:0]!=0.
REQ-023 Illegal funct3: 011, 110 or 111; also store with 100 or 101.
REQ-024 Store byte enables:
- byte: bus_be=4'b0001<<addr[1:0], bus_wdata = byte replicated on all 4 lanes.
- half: bus_be=4'b0011<<addr[1:0], bus_wdata = halfword replicated on both halves.
- word: bus_be=4'b1111.
REQ-025 Loads SHALL drive bus_be=4'b1111 and bus_we=0.
REQ-026 Load result: select the lane by addr[1:0]; sign-extend for 000/001, zero-extend for 100/101; word is passed through.
REQ-027 rdata SHALL update only on a successful load completion and hold its value otherwise.
REQ-028 Timeout counter: clears on REQ entry and increments each REQ cycle without bus_ready. When it reaches TIMEOUT-1 without bus_ready, go to DONE with err=1 and drop bus_valid.
REQ-029 bus_ready in the same cycle as the counter reaching TIMEOUT-1 SHALL count as success.
REQ-030 bus_ready outside REQ SHALL be ignored.

Reset
REQ-031 rst=1 SHALL immediately force IDLE with stall tracking req_valid.
REQ-032 During reset, bus_valid=0, done=0, err=0, rdata=0, bus_addr/bus_be/bus_wdata/bus_we=0 and counter=0.
REQ-033 Reset during REQ SHALL abort the transaction without a done pulse.

Verification
REQ-034 lb, addr=0x1003, bus_rdata=0x80FF_0000, zero wait -> done in cycle 2, rdata=0xFFFF_FF80, stall high in cycles 0-1.
REQ-035 sh, addr=0x2002, wdata=0x0000_ABCD, bus_ready after 3 waits -> bus_be=4'b1100, bus_wdata=0xABCD_ABCD, bus_addr=0x2000, done in cycle 5.
REQ-036 lw, addr=0x3001 -> no bus_valid, done=1 and err=1 in cycle 1, rdata unchanged.
REQ-037 lhu, addr=0x4002, bus_ready never asserted, TIMEOUT=16 -> bus_valid for 16 cycles, then done=1 and err=1.
REQ-038 rst asserted in the second REQ cycle of sw -> bus_valid=0 asynchronously, no done; a following lw completes normally.
REQ-039 Back-to-back sb then lbu -> second request accepted the cycle after DONE; both done pulses observed, each separated by an IDLE cycle.
